// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and sizing for the FIFO write arbiter.
//   arb_state_e  : arbiter FSM state (IDLE, BURST)
//   DEF_*        : default NUM_REQ / DATA_W / BURST_LEN and derived widths
//   cnt_w()      : counter/index width for a given range, never below 1 bit
package fifo_arb_pkg;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_BURST_LEN = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_IDX_W  = cnt_w(DEF_NUM_REQ);
  localparam int DEF_BEAT_W = cnt_w(DEF_BURST_LEN);

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req        in  NUM_REQ  candidate vector
//   last_owner in  IDX_W    previous winner; search starts at last_owner+1
//   sel_oh     out NUM_REQ  one-hot winner (0 when nothing requested)
//   sel_idx    out IDX_W    winner index
//   sel_vld    out 1        any requester selected
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = cnt_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_owner,
  output logic [NUM_REQ-1:0] sel_oh,
  output logic [IDX_W-1:0]   sel_idx,
  output logic               sel_vld
);

  logic [IDX_W-1:0] i;

  // Walk last_owner+1 .. last_owner+NUM_REQ (mod NUM_REQ); the previous
  // winner is visited last so it only wins again when alone.
  always_comb begin
    sel_oh  = '0;
    sel_idx = '0;
    sel_vld = 1'b0;
    i       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      i = IDX_W'((int'(last_owner) + k) % NUM_REQ);
      if (!sel_vld && req[i]) begin
        sel_vld   = 1'b1;
        sel_idx   = i;
        sel_oh[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing the fifo_mem write port
// between NUM_REQ producers, one bounded burst (BURST_LEN beats) per grant.
//   clk, rst_n      clock, synchronous active-low reset
//   req_valid/data  per-requester word offer (req i at [i*DATA_W +: DATA_W])
//   req_ready       per-requester accept, only the owner, only when not full
//   fifo_wr/data    write strobe and word towards fifo_mem
//   fifo_full       back-pressure, stalls the burst in place
//   fifo_threshold  blocks new grants when FIFO_ARB_THRESH_EN is defined,
//                   otherwise unused
//   fifo_overflow   counted into ovf_cnt (saturating at 255)
//   grant           registered one-hot owner, 0 in IDLE
//   busy            high in BURST
// Build option: `define FIFO_ARB_THRESH_EN to gate arbitration on threshold.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      fifo_wr,
  output logic [DATA_W-1:0]         fifo_data,
  input  logic                      fifo_full,
  input  logic                      fifo_threshold,
  input  logic                      fifo_overflow,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy,
  output logic [7:0]                ovf_cnt
);

  localparam int IDX_W  = cnt_w(NUM_REQ);
  localparam int BEAT_W = cnt_w(BURST_LEN);

  arb_state_e                        state, state_nxt;
  logic [IDX_W-1:0]                  last_owner;
  logic [BEAT_W-1:0]                 beat_cnt;
  logic [NUM_REQ-1:0][DATA_W-1:0]    data_arr;
  logic [NUM_REQ-1:0]                pick_oh;
  logic [IDX_W-1:0]                  pick_idx;
  logic                              pick_vld;
  logic                              arb_block;
  logic                              start_ok;
  logic                              own_valid;
  logic                              last_beat;
  logic                              xfer;

  assign data_arr = req_data;

`ifdef FIFO_ARB_THRESH_EN
  assign arb_block = fifo_threshold;
`else
  logic unused_thresh;
  assign unused_thresh = fifo_threshold;
  assign arb_block     = 1'b0;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req        (req_valid),
    .last_owner (last_owner),
    .sel_oh     (pick_oh),
    .sel_idx    (pick_idx),
    .sel_vld    (pick_vld)
  );

  // last_owner doubles as the current owner while in BURST.
  assign start_ok  = pick_vld && !arb_block;
  assign own_valid = req_valid[last_owner];
  assign last_beat = (beat_cnt == BEAT_W'(BURST_LEN - 1));

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next state: a burst ends on its last beat or when the owner goes idle;
  // a full FIFO with the owner still valid just holds.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start_ok) state_nxt = BURST;
      BURST: begin
        if (xfer) begin
          if (last_beat) state_nxt = IDLE;
        end else if (!own_valid) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // outputs: rst_n gates the strobes so a reset cycle never writes,
  // even if the burst state has not been cleared yet.
  always_comb begin
    busy      = 1'b0;
    req_ready = '0;
    xfer      = 1'b0;
    fifo_data = '0;
    if (state == BURST) begin
      busy      = 1'b1;
      fifo_data = data_arr[last_owner];
      if (rst_n && !fifo_full) req_ready = grant;
      xfer = rst_n && !fifo_full && own_valid;
    end
  end

  assign fifo_wr = xfer;

  // grant / owner / beat bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant      <= '0;
      last_owner <= IDX_W'(NUM_REQ - 1);
      beat_cnt   <= '0;
    end else if (state == IDLE) begin
      if (start_ok) begin
        grant      <= pick_oh;
        last_owner <= pick_idx;
        beat_cnt   <= '0;
      end
    end else begin
      if (xfer)               beat_cnt <= beat_cnt + 1'b1;
      if (state_nxt == IDLE) grant    <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                              ovf_cnt <= '0;
    else if (fifo_overflow && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: per-requester source tables feed
// the DUT, expected FIFO words (with owning grant) are queued when loaded
// and popped on every observed fifo_wr.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 8;
  localparam int BURST_LEN = 4;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      fifo_wr;
  logic [DATA_W-1:0]         fifo_data;
  logic                      fifo_full;
  logic                      fifo_threshold;
  logic                      fifo_overflow;
  logic [NUM_REQ-1:0]        grant;
  logic                      busy;
  logic [7:0]                ovf_cnt;

  fifo_wr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .DATA_W    (DATA_W),
    .BURST_LEN (BURST_LEN)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .fifo_wr        (fifo_wr),
    .fifo_data      (fifo_data),
    .fifo_full      (fifo_full),
    .fifo_threshold (fifo_threshold),
    .fifo_overflow  (fifo_overflow),
    .grant          (grant),
    .busy           (busy),
    .ovf_cnt        (ovf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0]  d;
    logic [NUM_REQ-1:0] g;
  } exp_t;

  exp_t              exp_q[$];
  logic [DATA_W-1:0] src_mem [NUM_REQ][16];
  int                src_rd  [NUM_REQ];
  int                src_cnt [NUM_REQ];
  int                checks, errors, cyc;
  int                wr_cyc[$];
  logic [NUM_REQ-1:0] obs_grant;
  logic              obs_busy;

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (src_rd[i] < src_cnt[i]) begin
        req_valid[i] = 1'b1;
        req_data[i*DATA_W +: DATA_W] = src_mem[i][src_rd[i]];
      end else begin
        req_valid[i] = 1'b0;
        req_data[i*DATA_W +: DATA_W] = 8'hA5;
      end
    end
  endtask

  task automatic load(input int r, input int base, input int n, input bit push);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      src_mem[r][src_cnt[r]] = DATA_W'(base + k);
      src_cnt[r]++;
      if (push) begin
        e.d = DATA_W'(base + k);
        e.g = NUM_REQ'(1) << r;
        exp_q.push_back(e);
      end
    end
  endtask

  // One clock: drive, observe at negedge, retire accepted words.
  task automatic step();
    exp_t e;
    drive();
    @(negedge clk);
    obs_grant = grant;
    obs_busy  = busy;
    if (fifo_wr) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_wr cyc=%0d data=%h grant=%b", cyc, fifo_data, grant);
      end else begin
        e = exp_q.pop_front();
        if (fifo_data !== e.d || grant !== e.g) begin
          errors++;
          $display("FAIL wr_word cyc=%0d got %h/%b exp %h/%b", cyc, fifo_data, grant, e.d, e.g);
        end
      end
      checks++;
      if (fifo_full !== 1'b0) begin
        errors++;
        $display("FAIL wr_while_full cyc=%0d", cyc);
      end
      wr_cyc.push_back(cyc);
    end else if (!busy) begin
      checks++;
      if (fifo_data !== '0) begin
        errors++;
        $display("FAIL idle_data cyc=%0d got %h exp 00", cyc, fifo_data);
      end
    end
    for (int i = 0; i < NUM_REQ; i++)
      if (req_valid[i] && req_ready[i]) src_rd[i]++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic reset_dut();
    rst_n          = 1'b0;
    fifo_full      = 1'b0;
    fifo_threshold = 1'b0;
    fifo_overflow  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      src_rd[i]  = 0;
      src_cnt[i] = 0;
    end
    exp_q.delete();
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
    wr_cyc.delete();
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 80 && exp_q.size() != 0; k++) step();
    repeat (3) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got %0d words left exp 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    fifo_full      = 1'b0;
    fifo_threshold = 1'b0;
    fifo_overflow  = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      src_rd[i]  = 0;
      src_cnt[i] = 0;
      load(i, 8'h80 + i * 8, 4, 1'b0);
    end
    drive();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (grant !== '0 || fifo_wr !== 1'b0 || req_ready !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got grant=%b wr=%b ready=%b busy=%b exp 0", grant, fifo_wr, req_ready, busy);
    end
    checks++;
    if (ovf_cnt !== 8'd0 || fifo_data !== '0) begin
      errors++;
      $display("FAIL reset_ovf got ovf=%0d data=%h exp 0/00", ovf_cnt, fifo_data);
    end
    fifo_overflow = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (grant !== 4'b0001 || req_ready !== 4'b0001 || fifo_wr !== 1'b1 || fifo_data !== 8'h80) begin
      errors++;
      $display("FAIL reset_first_grant got grant=%b ready=%b wr=%b data=%h exp 0001/0001/1/80",
               grant, req_ready, fifo_wr, fifo_data);
    end
  endtask

  task automatic test_reset_mid_burst();
    reset_dut();
    load(3, 8'h60, 4, 1'b0);
    exp_q.push_back('{d: 8'h60, g: 4'b1000});
    step();
    step();
    rst_n = 1'b0;
    drive();
    @(negedge clk);
    checks++;
    if (fifo_wr !== 1'b0 || req_ready !== '0) begin
      errors++;
      $display("FAIL reset_mid_wr got wr=%b ready=%b exp 0/0000", fifo_wr, req_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (grant !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_state got grant=%b busy=%b exp 0000/0", grant, busy);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_words got %0d left exp 0", exp_q.size());
    end
  endtask

  task automatic test_single();
    int exp_c[$] = '{1, 2, 3, 4, 6, 7};
    bit ok;
    reset_dut();
    load(2, 8'h10, 6, 1'b1);
    drain("single");
    ok = (wr_cyc.size() == exp_c.size());
    foreach (exp_c[k]) if (ok && wr_cyc[k] != exp_c[k]) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL single_timing got %p exp %p", wr_cyc, exp_c);
    end
  endtask

  task automatic test_contention();
    exp_t e;
    bit   ok;
    int   bad;
    reset_dut();
    for (int i = 0; i < NUM_REQ; i++) load(i, i * 16, 8, 1'b0);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NUM_REQ; i++)
        for (int k = r * BURST_LEN; k < (r + 1) * BURST_LEN; k++) begin
          e.d = DATA_W'(i * 16 + k);
          e.g = NUM_REQ'(1) << i;
          exp_q.push_back(e);
        end
    drain("contention");
    // each burst: 4 writes then one arbitration bubble
    ok  = (wr_cyc.size() == 32);
    bad = -1;
    for (int n = 0; n < 32 && ok; n++)
      if (wr_cyc[n] != 1 + 5 * (n / 4) + (n % 4)) begin
        ok  = 1'b0;
        bad = n;
      end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL contention_timing got writes=%0d bad_idx=%0d exp 32 at 1+5*(n/4)+n%%4",
               wr_cyc.size(), bad);
    end
  endtask

  task automatic test_full_stall();
    int exp_c[$] = '{1, 2, 6, 7, 9, 10};
    bit ok;
    reset_dut();
    load(1, 8'h30, 6, 1'b1);
    repeat (3) step();
    fifo_full = 1'b1;
    repeat (3) begin
      step();
      checks++;
      if (obs_grant !== 4'b0010 || obs_busy !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold got grant=%b busy=%b exp 0010/1", obs_grant, obs_busy);
      end
    end
    fifo_full = 1'b0;
    drain("stall");
    ok = (wr_cyc.size() == exp_c.size());
    foreach (exp_c[k]) if (ok && wr_cyc[k] != exp_c[k]) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stall_timing got %p exp %p", wr_cyc, exp_c);
    end
  endtask

  task automatic test_early_release();
    int exp_c[$] = '{1, 2, 5, 6};
    bit ok;
    reset_dut();
    load(1, 8'h40, 2, 1'b1);
    load(2, 8'h50, 2, 1'b1);
    drain("release");
    ok = (wr_cyc.size() == exp_c.size());
    foreach (exp_c[k]) if (ok && wr_cyc[k] != exp_c[k]) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL release_timing got %p exp %p", wr_cyc, exp_c);
    end
  endtask

  task automatic test_threshold();
    bit ok;
`ifdef FIFO_ARB_THRESH_EN
    int exp_c[$] = '{4, 5};
`else
    int exp_c[$] = '{1, 2};
`endif
    reset_dut();
    fifo_threshold = 1'b1;
    load(0, 8'h70, 2, 1'b1);
    repeat (3) step();
`ifdef FIFO_ARB_THRESH_EN
    checks++;
    if (obs_grant !== '0 || wr_cyc.size() != 0) begin
      errors++;
      $display("FAIL thresh_block got grant=%b writes=%0d exp 0000/0", obs_grant, wr_cyc.size());
    end
`endif
    fifo_threshold = 1'b0;
    drain("thresh");
    ok = (wr_cyc.size() == exp_c.size());
    foreach (exp_c[k]) if (ok && wr_cyc[k] != exp_c[k]) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL thresh_timing got %p exp %p", wr_cyc, exp_c);
    end
  endtask

  task automatic test_overflow();
    reset_dut();
    fifo_overflow = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (ovf_cnt !== 8'd10) begin
      errors++;
      $display("FAIL ovf_count got %0d exp 10", ovf_cnt);
    end
    repeat (290) @(posedge clk);
    #1;
    checks++;
    if (ovf_cnt !== 8'd255) begin
      errors++;
      $display("FAIL ovf_saturate got %0d exp 255", ovf_cnt);
    end
    fifo_overflow = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    test_reset();
    test_reset_mid_burst();
    test_single();
    test_contention();
    test_full_stall();
    test_early_release();
    test_threshold();
    test_overflow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

endmodule
